// File: rtl/rn_ro_queue.sv
// Multi-lane valid/ready decoupling queue between rename and read-operand stages.
// Optional selective flush of younger instructions is enabled by defining RN_RO_SEL_FLUSH_EN.
module rn_ro_queue #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 96,
    parameter int ROB_W     = 5,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
`ifdef RN_RO_SEL_FLUSH_EN
    input  logic                       sel_flush,
    input  logic [ROB_W-1:0]           sel_flush_idx,
    input  logic [ROB_W-1:0]           rob_head,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_lane_valid,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    input  logic [LANES*ROB_W-1:0]     in_rob_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    output logic [LANES*ROB_W-1:0]     out_rob_idx,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]           r_rp;
    logic [PTR_W-1:0]           r_wp;
    logic [CNT_W-1:0]           r_cnt;
    logic [LANES-1:0]           r_lv  [DEPTH];
    logic [LANES*PAYLOAD_W-1:0] r_pl  [DEPTH];
    logic [LANES*ROB_W-1:0]     r_rob [DEPTH];

    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [LANES-1:0]           w_in_kill;
    logic [LANES-1:0]           w_st_kill [DEPTH];

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    assign in_ready  = ~w_full & ~rst;
    assign out_valid = ~w_empty;

    // flush discards any same-edge transfer on either side
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

`ifdef RN_RO_SEL_FLUSH_EN
    // Age is measured relative to the ROB head so that index wrap-around orders correctly.
    function automatic logic is_younger(input logic [ROB_W-1:0] idx,
                                        input logic [ROB_W-1:0] head,
                                        input logic [ROB_W-1:0] ref_idx);
        logic [ROB_W-1:0] a;
        logic [ROB_W-1:0] b;
        a = idx - head;
        b = ref_idx - head;
        return a > b;
    endfunction

    always_comb begin
        w_in_kill = '0;
        for (int e = 0; e < DEPTH; e++) w_st_kill[e] = '0;
        if (sel_flush && !flush) begin
            for (int l = 0; l < LANES; l++) begin
                w_in_kill[l] = is_younger(in_rob_idx[l*ROB_W +: ROB_W], rob_head, sel_flush_idx);
                for (int e = 0; e < DEPTH; e++)
                    w_st_kill[e][l] = is_younger(r_rob[e][l*ROB_W +: ROB_W], rob_head, sel_flush_idx);
            end
        end
    end
`else
    always_comb begin
        w_in_kill = '0;
        for (int e = 0; e < DEPTH; e++) w_st_kill[e] = '0;
    end
`endif

    // Storage is not reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_push && (r_wp == PTR_W'(e))) begin
                r_lv[e]  <= in_lane_valid & ~w_in_kill;
                r_pl[e]  <= in_payload;
                r_rob[e] <= in_rob_idx;
            end else begin
                r_lv[e]  <= r_lv[e] & ~w_st_kill[e];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rp  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rp  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_lane_valid = w_empty ? '0 : r_lv[r_rp];
    assign out_payload    = w_empty ? '0 : r_pl[r_rp];
    assign out_rob_idx    = w_empty ? '0 : r_rob[r_rp];
    assign occupancy      = r_cnt;

endmodule

// File: tb/tb_rn_ro_queue.sv
// Bench for rn_ro_queue: table-driven handshake vectors with a data scoreboard,
// plus hand-written reset and (when RN_RO_SEL_FLUSH_EN is defined) selective-flush sequences.
module tb_rn_ro_queue;
    localparam int LANES = 2;
    localparam int PW    = 96;
    localparam int RW    = 5;
    localparam int D     = 4;
    localparam int EW    = LANES + LANES*PW + LANES*RW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_lane_valid;
    logic [LANES*PW-1:0]   in_payload;
    logic [LANES*RW-1:0]   in_rob_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_lane_valid;
    logic [LANES*PW-1:0]   out_payload;
    logic [LANES*RW-1:0]   out_rob_idx;
    logic [2:0]            occupancy;
`ifdef RN_RO_SEL_FLUSH_EN
    logic                  sel_flush;
    logic [RW-1:0]         sel_flush_idx;
    logic [RW-1:0]         rob_head;
`endif

    rn_ro_queue #(.LANES(LANES), .PAYLOAD_W(PW), .ROB_W(RW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef RN_RO_SEL_FLUSH_EN
        .sel_flush(sel_flush), .sel_flush_idx(sel_flush_idx), .rob_head(rob_head),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
        .in_payload(in_payload), .in_rob_idx(in_rob_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_payload(out_payload), .out_rob_idx(out_rob_idx), .occupancy(occupancy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] lv;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_occ;
    } vec_t;

    vec_t            vecs[$];
    logic [EW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    logic [LANES*PW-1:0] cur_pl;
    logic [LANES*RW-1:0] cur_rob;
    logic            need_new = 1'b1;

    function automatic vec_t mk(input logic iv, input logic [1:0] lv, input logic ordy,
                                input logic fl, input logic ir, input logic ov,
                                input logic [2:0] occ);
        vec_t v;
        v.iv = iv; v.lv = lv; v.ordy = ordy; v.fl = fl;
        v.e_ir = ir; v.e_ov = ov; v.e_occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_empty_data(input string tag);
        check({tag, "_lv0"},  256'(out_lane_valid), 256'(0));
        check({tag, "_pl0"},  256'(out_payload),    256'(0));
        check({tag, "_rob0"}, 256'(out_rob_idx),    256'(0));
    endtask

    // driver: one table row per clock; outputs sampled 1 time unit after the falling edge
    task automatic apply_row(input vec_t v, input int i);
        logic [EW-1:0] head;
        @(negedge clk);
        if (need_new && v.iv) begin
            for (int k = 0; k < (LANES*PW)/32; k++) cur_pl[k*32 +: 32] = $urandom;
            cur_rob  = {RW'(i + 4), RW'(i + 3)};
            need_new = 1'b0;
        end
        in_valid      = v.iv;
        in_lane_valid = v.lv;
        in_payload    = cur_pl;
        in_rob_idx    = cur_rob;
        out_ready     = v.ordy;
        flush         = v.fl;
        #1;
        check($sformatf("row%0d_in_ready", i),  256'(in_ready),  256'(v.e_ir));
        check($sformatf("row%0d_out_valid", i), 256'(out_valid), 256'(v.e_ov));
        check($sformatf("row%0d_occupancy", i), 256'(occupancy), 256'(v.e_occ));
        if (v.e_ov) begin
            head = {out_lane_valid, out_payload, out_rob_idx};
            if (exp_q.size() == 0) check($sformatf("row%0d_sb_empty", i), 256'(1), 256'(0));
            else check($sformatf("row%0d_head", i), 256'(head), 256'(exp_q[0]));
        end else begin
            check_empty_data($sformatf("row%0d", i));
        end
        @(posedge clk);
        if (v.fl) begin
            exp_q.delete();
            need_new = 1'b1;
        end else begin
            if (v.e_ov && v.ordy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (v.iv && v.e_ir) begin
                exp_q.push_back({v.lv, cur_pl, cur_rob});
                need_new = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_lane_valid = '0; in_payload = '0; in_rob_idx = '0; cur_pl = '0; cur_rob = '0;
`ifdef RN_RO_SEL_FLUSH_EN
        sel_flush = 1'b0; sel_flush_idx = '0; rob_head = '0;
`endif
        // single-group latency, back-pressure to full, wrap streaming, flush
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));

        // reset state
        #3;
        check("rst_in_ready",  256'(in_ready),  256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check_empty_data("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'(1));

        for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);

        // asynchronous reset mid-cycle while two groups are stored and a push is pending
        apply_row(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0), 100);
        apply_row(mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1), 101);
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("pre_arst_occupancy", 256'(occupancy), 256'(2));
        #($urandom_range(1, 2));
        rst = 1'b1;
        #1;
        check("arst_out_valid", 256'(out_valid), 256'(0));
        check("arst_in_ready",  256'(in_ready),  256'(0));
        check("arst_occupancy", 256'(occupancy), 256'(0));
        check_empty_data("arst");
        exp_q.delete();
        need_new = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_release_in_ready", 256'(in_ready), 256'(1));
        check("arst_release_occ",      256'(occupancy), 256'(0));

`ifdef RN_RO_SEL_FLUSH_EN
        // selective flush with ROB index wrap-around: head=30, lanes {31,0} and {1,2}
        @(negedge clk);
        in_valid = 1'b1; in_lane_valid = 2'b11; out_ready = 1'b0;
        in_payload = {6{32'hA5A5_0001}}; in_rob_idx = {RW'(0), RW'(31)};
        @(negedge clk);
        in_payload = {6{32'hA5A5_0002}}; in_rob_idx = {RW'(2), RW'(1)};
        @(negedge clk);
        in_valid = 1'b0;
        sel_flush = 1'b1; rob_head = RW'(30); sel_flush_idx = RW'(0);
        @(negedge clk);
        sel_flush = 1'b0;
        #1;
        check("sel_occupancy", 256'(occupancy),      256'(2));
        check("sel_g0_lv",     256'(out_lane_valid), 256'(2'b11));
        check("sel_g0_rob",    256'(out_rob_idx),    256'({RW'(0), RW'(31)}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("sel_g1_valid",  256'(out_valid),      256'(1));
        check("sel_g1_lv",     256'(out_lane_valid), 256'(2'b00));
        check("sel_g1_pl",     256'(out_payload),    256'({6{32'hA5A5_0002}}));
        check("sel_g1_rob",    256'(out_rob_idx),    256'({RW'(2), RW'(1)}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("sel_drained_occ", 256'(occupancy), 256'(0));
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
